vc_fifo: RTL and testbench

VC_FIFO -- requirements
Module: vc_fifo

---
 rtl/vc_fifo.sv | 125 ++++++++++++
 tb/tb_vc_fifo.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vc_fifo.sv
// rtl/vc_fifo.sv - multi-VC flit FIFO with per-VC status, credit return and sticky errors
// Each VC is an independent circular buffer sharing one write and one read port.
module vc_fifo #(
  parameter int DSIZE    = 32,
  parameter int ADDRSIZE = 3,
  parameter int NUM_VC   = 2,
  parameter int VCW      = 1,
  parameter int AFULL_TH = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DSIZE-1:0]             wdata,
  input  logic                         winc,
  input  logic [VCW-1:0]               wvc,
  input  logic                         rinc,
  input  logic [VCW-1:0]               rvc,
  output logic [DSIZE-1:0]             rdata,
  output logic                         rvalid,
  output logic [NUM_VC-1:0]            wfull,
  output logic [NUM_VC-1:0]            rempty,
  output logic [NUM_VC-1:0]            afull,
  output logic [NUM_VC*(ADDRSIZE+1)-1:0] count,
  output logic [NUM_VC-1:0]            credit,
  output logic                         werr,
  output logic                         rerr
);

  localparam int PW = ADDRSIZE + 1;
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [VCW:0] NVC = NUM_VC[VCW:0];

  logic [DSIZE-1:0] mem_q [NUM_VC][DEPTH];

  logic [PW-1:0] wptr_q [NUM_VC];
  logic [PW-1:0] wptr_d [NUM_VC];
  logic [PW-1:0] rptr_q [NUM_VC];
  logic [PW-1:0] rptr_d [NUM_VC];

  logic [NUM_VC-1:0]    wfull_q, wfull_d;
  logic [NUM_VC-1:0]    rempty_q, rempty_d;
  logic [NUM_VC-1:0]    afull_q, afull_d;
  logic [NUM_VC-1:0]    credit_q, credit_d;
  logic [NUM_VC*PW-1:0] count_q, count_d;
  logic [DSIZE-1:0]     rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;
  logic                 werr_q, werr_d;
  logic                 rerr_q, rerr_d;

  logic          wr_ok, rd_ok;
  logic [PW-1:0] occ;

  always_comb begin
    wr_ok    = 1'b0;
    rd_ok    = 1'b0;
    occ      = '0;
    wfull_d  = '0;
    rempty_d = '0;
    afull_d  = '0;
    credit_d = '0;
    count_d  = '0;
    rdata_d  = rdata_q;
    // Acceptance uses only registered flags, so a same-cycle pop never frees room
    // for a push and a same-cycle push never feeds a pop.
    if (winc && ({1'b0, wvc} < NVC)) wr_ok = !wfull_q[wvc];
    if (rinc && ({1'b0, rvc} < NVC)) rd_ok = !rempty_q[rvc];
    for (int v = 0; v < NUM_VC; v++) begin
      wptr_d[v] = wptr_q[v] + PW'(wr_ok && (wvc == VCW'(v)));
      rptr_d[v] = rptr_q[v] + PW'(rd_ok && (rvc == VCW'(v)));
      occ = wptr_d[v] - rptr_d[v];
      count_d[v*PW +: PW] = occ;
      wfull_d[v]  = (wptr_d[v][PW-1] != rptr_d[v][PW-1]) &&
                    (wptr_d[v][PW-2:0] == rptr_d[v][PW-2:0]);
      rempty_d[v] = (wptr_d[v] == rptr_d[v]);
      afull_d[v]  = (occ >= PW'(AFULL_TH));
      credit_d[v] = rd_ok && (rvc == VCW'(v));
    end
    if (rd_ok) rdata_d = mem_q[rvc][rptr_q[rvc][ADDRSIZE-1:0]];
    rvalid_d = rd_ok;
    werr_d   = werr_q | (winc & ~wr_ok);
    rerr_d   = rerr_q | (rinc & ~rd_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem_q[wvc][wptr_q[wvc][ADDRSIZE-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '{default: '0};
      rptr_q   <= '{default: '0};
      wfull_q  <= '0;
      rempty_q <= '1;
      afull_q  <= '0;
      credit_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      werr_q   <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      afull_q  <= afull_d;
      credit_q <= credit_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      werr_q   <= werr_d;
      rerr_q   <= rerr_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign wfull  = wfull_q;
  assign rempty = rempty_q;
  assign afull  = afull_q;
  assign count  = count_q;
  assign credit = credit_q;
  assign werr   = werr_q;
  assign rerr   = rerr_q;

endmodule

// File: tb/tb_vc_fifo.sv
// tb/tb_vc_fifo.sv - self-checking bench for vc_fifo
module tb_vc_fifo;
  localparam int DS = 32;
  localparam int AS = 3;
  localparam int NV = 2;
  localparam int VW = 1;
  localparam int PW = AS + 1;

  logic clk = 1'b0;
  logic rst, winc, rinc;
  logic [VW-1:0] wvc, rvc;
  logic [DS-1:0] wdata, rdata;
  logic rvalid, werr, rerr;
  logic [NV-1:0] wfull, rempty, afull, credit;
  logic [NV*PW-1:0] count;

  int total = 0;
  int bad = 0;

  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  logic [31:0] sb_q[$];
  logic m_werr, m_rerr;

  typedef struct {
    logic        wi;
    logic        wv;
    logic [31:0] wd;
    logic        ri;
    logic        rv;
    logic        e_rvalid;
    logic [31:0] e_rdata;
    logic [3:0]  e_cnt0;
    logic        e_credit0;
    logic        e_rerr;
    logic        e_rempty0;
  } vec_t;

  vec_t tbl[10];

  vc_fifo #(.DSIZE(DS), .ADDRSIZE(AS), .NUM_VC(NV), .VCW(VW), .AFULL_TH(6)) dut (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .wvc(wvc), .rinc(rinc), .rvc(rvc),
    .rdata(rdata), .rvalid(rvalid), .wfull(wfull), .rempty(rempty), .afull(afull),
    .count(count), .credit(credit), .werr(werr), .rerr(rerr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input logic busy);
    rst = 1'b1; winc = busy; wvc = 1'b0; wdata = 32'hDEAD; rinc = busy; rvc = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; winc = 1'b0; rinc = 1'b0;
    mq0.delete(); mq1.delete(); sb_q.delete();
    m_werr = 1'b0; m_rerr = 1'b0;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_rempty", 32'(rempty), 32'h3);
    chk("rst_wfull", 32'(wfull), 32'h0);
    chk("rst_afull", 32'(afull), 32'h0);
    chk("rst_credit", 32'(credit), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_werr", 32'(werr), 32'h0);
    chk("rst_rerr", 32'(rerr), 32'h0);
  endtask

  task automatic step(input logic wi, input logic wv, input logic [31:0] wd,
                      input logic ri, input logic rv);
    logic wacc, racc;
    int s0, s1;
    logic [31:0] e;
    s0 = mq0.size(); s1 = mq1.size();
    wacc = wi && ((wv == 1'b0) ? (s0 < 8) : (s1 < 8));
    racc = ri && ((rv == 1'b0) ? (s0 > 0) : (s1 > 0));
    if (racc) begin
      if (rv == 1'b0) e = mq0.pop_front(); else e = mq1.pop_front();
      sb_q.push_back(e);
    end
    if (wacc) begin
      if (wv == 1'b0) mq0.push_back(wd); else mq1.push_back(wd);
    end
    if (wi && !wacc) m_werr = 1'b1;
    if (ri && !racc) m_rerr = 1'b1;
    winc = wi; wvc = wv; wdata = wd; rinc = ri; rvc = rv;
    @(posedge clk); #1;
    winc = 1'b0; rinc = 1'b0;
    chk("rvalid", 32'(rvalid), 32'(racc));
    if (rvalid) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rdata_unexpected: got=%0h expected=none", rdata);
      end else begin
        chk("rdata", rdata, sb_q.pop_front());
      end
    end
    chk("credit", 32'(credit), racc ? (rv ? 32'h2 : 32'h1) : 32'h0);
    chk("count0", 32'(count[3:0]), 32'(mq0.size()));
    chk("count1", 32'(count[7:4]), 32'(mq1.size()));
    chk("wfull", 32'(wfull), 32'({mq1.size() == 8, mq0.size() == 8}));
    chk("rempty", 32'(rempty), 32'({mq1.size() == 0, mq0.size() == 0}));
    chk("afull", 32'(afull), 32'({mq1.size() >= 6, mq0.size() >= 6}));
    chk("werr", 32'(werr), 32'(m_werr));
    chk("rerr", 32'(rerr), 32'(m_rerr));
  endtask

  initial begin
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; wvc = 1'b0; rvc = 1'b0; wdata = '0;
    tbl[0] = '{1'b1, 1'b0, 32'h0000BBBB, 1'b0, 1'b0, 1'b0, 32'h0,        4'd1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 32'h00010001, 1'b0, 1'b0, 1'b0, 32'h0,        4'd2, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0000BBBB, 4'd1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h00010001, 4'd0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h00010001, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h00010001, 4'd0, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 32'h55,       1'b1, 1'b0, 1'b0, 32'h00010001, 4'd1, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 32'h66,       1'b1, 1'b0, 1'b1, 32'h55,       4'd1, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h66,       4'd0, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h66,       4'd0, 1'b0, 1'b1, 1'b1};

    @(posedge clk); #1;
    do_reset(1'b0);

    for (int i = 0; i < 10; i++) begin
      winc = tbl[i].wi; wvc = tbl[i].wv; wdata = tbl[i].wd; rinc = tbl[i].ri; rvc = tbl[i].rv;
      @(posedge clk); #1;
      winc = 1'b0; rinc = 1'b0;
      chk($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].e_rvalid));
      chk($sformatf("v%0d_rdata", i), rdata, tbl[i].e_rdata);
      chk($sformatf("v%0d_count0", i), 32'(count[3:0]), 32'(tbl[i].e_cnt0));
      chk($sformatf("v%0d_credit0", i), 32'(credit[0]), 32'(tbl[i].e_credit0));
      chk($sformatf("v%0d_rerr", i), 32'(rerr), 32'(tbl[i].e_rerr));
      chk($sformatf("v%0d_rempty0", i), 32'(rempty[0]), 32'(tbl[i].e_rempty0));
    end

    do_reset(1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 32'hC000 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hC0FF, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hC100, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 32'hA0 + 32'(i), 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 32'hB9, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'(r * 8 + i), 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h100 + 32'(i), i > 0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'hE0 + 32'(i), 1'b0, 1'b0);
    do_reset(1'b1);
    step(1'b1, 1'b0, 32'h77, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
